// File: rtl/tpu_issue_buff.sv
// tpu_issue_buff: multi-channel instruction issue buffer.
// One FIFO per thread context holds coupled {instr, thread-ID} entries,
// a round-robin arbiter presents one head per cycle in first-word
// fall-through fashion, and each channel can be flushed independently.
module tpu_issue_buff #(
  parameter int NUM_ENTRY   = 16,
  parameter int NUM_CH      = 2,
  parameter int WIDTH_INSTR = 64,
  parameter int WIDTH_ID    = 8,
  parameter int AFULL_TH    = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W      = $clog2(NUM_ENTRY) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_We,
  input  logic [CH_W-1:0]        I_Ch,
  input  logic [WIDTH_INSTR-1:0] I_Instr,
  input  logic [WIDTH_ID-1:0]    I_ThreadID,
  input  logic [NUM_CH-1:0]      I_Flush,
  input  logic                   I_Re,
  output logic                   O_Valid,
  output logic [WIDTH_INSTR-1:0] O_Instr,
  output logic [WIDTH_ID-1:0]    O_ThreadID,
  output logic [CH_W-1:0]        O_Ch,
  output logic [NUM_CH-1:0]      O_Full,
  output logic [NUM_CH-1:0]      O_AFull,
  output logic                   O_Empty,
  output logic                   O_Nack
);

  localparam int ENTRY_W = WIDTH_INSTR + WIDTH_ID;

  logic [ENTRY_W-1:0] r_mem   [NUM_CH][NUM_ENTRY];
  logic [PTR_W-1:0]   r_wrPtr [NUM_CH];
  logic [PTR_W-1:0]   r_rdPtr [NUM_CH];
  logic [CH_W-1:0]    r_rr;
  logic               r_nack;

  logic [PTR_W-1:0]   w_count [NUM_CH];
  logic [NUM_CH-1:0]  w_empty;
  logic [NUM_CH-1:0]  w_full;
  logic [NUM_CH-1:0]  w_afull;
  logic [CH_W-1:0]    w_grant;
  logic               w_valid;
  logic               w_pop;
  logic               w_chOk;
  logic [CH_W-1:0]    w_wrCh;
  logic               w_wrAcc;
  logic               w_nack;
  logic [ENTRY_W-1:0] w_head;

  // Per-channel occupancy; the extra pointer MSB lets count reach NUM_ENTRY.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_count[c] = r_wrPtr[c] - r_rdPtr[c];
      w_empty[c] = (w_count[c] == '0);
      w_full[c]  = (w_count[c] == PTR_W'(NUM_ENTRY));
      w_afull[c] = ((NUM_ENTRY - int'(w_count[c])) <= AFULL_TH);
    end
  end

  // Round-robin grant: first non-empty channel at or after the RR pointer.
  always_comb begin
    w_valid = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_valid && !w_empty[(int'(r_rr) + i) % NUM_CH]) begin
        w_valid = 1'b1;
        w_grant = CH_W'((int'(r_rr) + i) % NUM_CH);
      end
    end
  end

  // Write acceptance; flush wins silently, full or bad channel raises a Nack.
  always_comb begin
    w_chOk  = (int'(I_Ch) < NUM_CH);
    w_wrCh  = w_chOk ? I_Ch : '0;
    w_wrAcc = I_We && w_chOk && !w_full[w_wrCh] && !I_Flush[w_wrCh];
    w_nack  = I_We && (!w_chOk || (w_full[w_wrCh] && !I_Flush[w_wrCh]));
    w_pop   = w_valid && I_Re && !I_Flush[w_grant];
    w_head  = r_mem[w_grant][r_rdPtr[w_grant][PTR_W-2:0]];
  end

  // Entry storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (w_wrAcc) begin
      r_mem[w_wrCh][r_wrPtr[w_wrCh][PTR_W-2:0]] <= {I_Instr, I_ThreadID};
    end
  end

  // Pointer, round-robin and Nack state; flush clears a channel outright.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wrPtr[c] <= '0;
        r_rdPtr[c] <= '0;
      end
      r_rr   <= '0;
      r_nack <= 1'b0;
    end else begin
      r_nack <= w_nack;
      for (int c = 0; c < NUM_CH; c++) begin
        if (I_Flush[c]) begin
          r_wrPtr[c] <= '0;
          r_rdPtr[c] <= '0;
        end else begin
          if (w_wrAcc && (int'(w_wrCh) == c)) begin
            r_wrPtr[c] <= r_wrPtr[c] + PTR_W'(1);
          end
          if (w_pop && (int'(w_grant) == c)) begin
            r_rdPtr[c] <= r_rdPtr[c] + PTR_W'(1);
          end
        end
      end
      if (w_pop) begin
        r_rr <= (int'(w_grant) == NUM_CH - 1) ? '0 : w_grant + CH_W'(1);
      end
    end
  end

  assign O_Valid    = w_valid;
  assign O_Instr    = w_valid ? w_head[ENTRY_W-1:WIDTH_ID] : '0;
  assign O_ThreadID = w_valid ? w_head[WIDTH_ID-1:0] : '0;
  assign O_Ch       = w_valid ? w_grant : '0;
  assign O_Full     = w_full;
  assign O_AFull    = w_afull;
  assign O_Empty    = &w_empty;
  assign O_Nack     = r_nack;

endmodule

// File: tb/tb_tpu_issue_buff.sv
// tb_tpu_issue_buff: randomized and directed bench for tpu_issue_buff.
// A queue-per-channel reference model predicts issue order; predicted issues
// go into a scoreboard that a separate monitor drains on each handshake.
module tb_tpu_issue_buff;
  localparam int NE = 16;
  localparam int NC = 2;
  localparam int AT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_We;
  logic [0:0]  I_Ch;
  logic [63:0] I_Instr;
  logic [7:0]  I_ThreadID;
  logic [1:0]  I_Flush;
  logic        I_Re;
  logic        O_Valid;
  logic [63:0] O_Instr;
  logic [7:0]  O_ThreadID;
  logic [0:0]  O_Ch;
  logic [1:0]  O_Full;
  logic [1:0]  O_AFull;
  logic        O_Empty;
  logic        O_Nack;

  typedef struct packed {
    logic [0:0]  ch;
    logic [63:0] instr;
    logic [7:0]  id;
  } item_t;

  item_t       expQ[$];
  logic [71:0] mq[NC][$];
  int          mRr;
  logic        mNack;
  int          total = 0;
  int          bad = 0;
  item_t       monItem;

  tpu_issue_buff #(
    .NUM_ENTRY(NE), .NUM_CH(NC), .WIDTH_INSTR(64), .WIDTH_ID(8), .AFULL_TH(AT)
  ) dut (
    .clock(clock), .reset(reset), .I_We(I_We), .I_Ch(I_Ch), .I_Instr(I_Instr),
    .I_ThreadID(I_ThreadID), .I_Flush(I_Flush), .I_Re(I_Re), .O_Valid(O_Valid),
    .O_Instr(O_Instr), .O_ThreadID(O_ThreadID), .O_Ch(O_Ch), .O_Full(O_Full),
    .O_AFull(O_AFull), .O_Empty(O_Empty), .O_Nack(O_Nack)
  );

  always #5 clock = ~clock;

  // Single comparison with a FAIL line on mismatch.
  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Channel the model would grant, or -1 when everything is empty.
  function automatic int modelGrant();
    for (int i = 0; i < NC; i++) begin
      if (mq[(mRr + i) % NC].size() > 0) return (mRr + i) % NC;
    end
    return -1;
  endfunction

  // Advance the model by one clock given this cycle's inputs.
  task automatic modelStep(input logic we, input logic [0:0] ch, input logic [63:0] instr,
                           input logic [7:0] id, input logic [1:0] flush, input logic re);
    int          g;
    logic        wasFull;
    logic [71:0] h;
    item_t       it;
    g = modelGrant();
    wasFull = (mq[ch].size() == NE);
    mNack = we && !flush[ch] && wasFull;
    if (re && g >= 0 && !flush[g]) begin
      h = mq[g].pop_front();
      it.ch = g[0:0];
      it.instr = h[71:8];
      it.id = h[7:0];
      expQ.push_back(it);
      mRr = (g + 1) % NC;
    end
    if (we && !flush[ch] && !wasFull) mq[ch].push_back({instr, id});
    for (int c = 0; c < NC; c++) begin
      if (flush[c]) mq[c].delete();
    end
  endtask

  // Compare every DUT output against the model's current state.
  task automatic checkOutput();
    int          g;
    logic [71:0] h;
    logic [1:0]  ef;
    logic [1:0]  eaf;
    g = modelGrant();
    for (int c = 0; c < NC; c++) begin
      ef[c]  = (mq[c].size() == NE);
      eaf[c] = ((NE - mq[c].size()) <= AT);
    end
    checkVal("valid", O_Valid, g >= 0);
    checkVal("empty", O_Empty, g < 0);
    checkVal("full", O_Full, ef);
    checkVal("afull", O_AFull, eaf);
    checkVal("nack", O_Nack, mNack);
    if (g >= 0) begin
      h = mq[g][0];
      checkVal("ch", O_Ch, g);
      checkVal("instr", O_Instr, h[71:8]);
      checkVal("id", O_ThreadID, h[7:0]);
    end else begin
      checkVal("ch_idle", O_Ch, 0);
      checkVal("instr_idle", O_Instr, 0);
      checkVal("id_idle", O_ThreadID, 0);
    end
  endtask

  // Drive one cycle (called just after a rising edge), clock it, then check.
  task automatic applyStimulus(input logic we, input logic [0:0] ch, input logic [63:0] instr,
                               input logic [7:0] id, input logic [1:0] flush, input logic re);
    I_We = we;
    I_Ch = ch;
    I_Instr = instr;
    I_ThreadID = id;
    I_Flush = flush;
    I_Re = re;
    modelStep(we, ch, instr, id, flush, re);
    @(posedge clock);
    #2;
    checkOutput();
  endtask

  // Monitor: every real handshake must match the next predicted issue.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && O_Valid && I_Re && !I_Flush[O_Ch]) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL issue_unexpected actual=%0h_%0h_%0h required=none", O_Ch, O_Instr, O_ThreadID);
        end else begin
          monItem = expQ.pop_front();
          if ({O_Ch, O_Instr, O_ThreadID} !== monItem) begin
            bad++;
            $display("[TB] FAIL issue_order actual=%0h required=%0h", {O_Ch, O_Instr, O_ThreadID}, monItem);
          end
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    I_We = 1'b0; I_Ch = '0; I_Instr = '0; I_ThreadID = '0; I_Flush = '0; I_Re = 1'b0;
    mRr = 0;
    mNack = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    checkOutput();

    $display("[TB] single write");
    applyStimulus(1'b1, 1'b0, 64'h11, 8'd3, 2'b00, 1'b0);
    checkVal("first_instr", O_Instr, 64'h11);
    checkVal("first_id", O_ThreadID, 8'd3);
    checkVal("first_valid", O_Valid, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b1);

    $display("[TB] fill ch1");
    for (int i = 0; i < NE; i++) begin
      applyStimulus(1'b1, 1'b1, 64'h100 + 64'(i), 8'(i), 2'b00, 1'b0);
      if (i == NE - 3) checkVal("afull_at_14", O_AFull[1], 1'b1);
    end
    checkVal("full_at_16", O_Full[1], 1'b1);
    applyStimulus(1'b1, 1'b1, 64'hDEAD, 8'hEE, 2'b00, 1'b0);
    checkVal("nack_17th", O_Nack, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b0);
    checkVal("nack_pulse_end", O_Nack, 1'b0);
    for (int i = 0; i < NE + 1; i++) applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b1);

    $display("[TB] round robin 3+3");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 64'hA0 + 64'(i), 8'(i), 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 64'hB0 + 64'(i), 8'(16 + i), 2'b00, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b1);
    checkVal("rr_done_empty", O_Empty, 1'b1);

    $display("[TB] wrap-around");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 64'hC00 + 64'(i), 8'(i), 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b1);

    $display("[TB] flush");
    applyStimulus(1'b1, 1'b1, 64'hE1, 8'h51, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'hE2, 8'h52, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'hF1, 8'h61, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'hF2, 8'h62, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b0, 64'hF3, 8'h63, 2'b01, 1'b1);
    checkVal("flush_ch1_kept", O_ThreadID, 8'h52);
    checkVal("flush_no_nack", O_Nack, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    8'($urandom_range(0, 255)),
                    {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)},
                    ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 2 * NE + 2; i++) applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b1);

    $display("[TB] async reset with ch0 full");
    for (int i = 0; i < NE; i++) applyStimulus(1'b1, 1'b0, 64'h700 + 64'(i), 8'(i), 2'b00, 1'b0);
    I_We = 1'b0;
    reset = 1'b1;
    #1;
    checkVal("rst_valid", O_Valid, 1'b0);
    checkVal("rst_instr", O_Instr, 64'h0);
    checkVal("rst_id", O_ThreadID, 8'h0);
    checkVal("rst_ch", O_Ch, 1'b0);
    checkVal("rst_full", O_Full, 2'b00);
    checkVal("rst_afull", O_AFull, 2'b00);
    checkVal("rst_empty", O_Empty, 1'b1);
    checkVal("rst_nack", O_Nack, 1'b0);
    #1;
    reset = 1'b0;
    for (int c = 0; c < NC; c++) mq[c].delete();
    mRr = 0;
    mNack = 1'b0;
    @(posedge clock);
    #2;
    checkOutput();
    applyStimulus(1'b1, 1'b1, 64'h99, 8'h9, 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'h0, 8'd0, 2'b00, 1'b0);

    checkVal("scoreboard_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
